// File: rtl/matrix_mul_pkg.sv
// matrix_mul_pkg: shared state enum, default sizes and index-width helpers for the matrix multiply core
package matrix_mul_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ACC_W = 40;
  localparam int DEF_MAX = 8;
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, COMPUTE, DRAIN} state_t;
  function automatic int dim_w(input int mx);
    return $clog2(mx) + 1;
  endfunction
  function automatic int addr_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/mac_unit.sv
// mac_unit: signed DATA_W multiply, sign-extend to ACC_W, seed-or-accumulate register (clk, rst, en, first, seed, a, b -> acc)
module mac_unit #(
  parameter int DATA_W = 16,
  parameter int ACC_W = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              first,
  input  logic [ACC_W-1:0]  seed,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0] ext;
  assign prod = $signed(a) * $signed(b);
  assign ext = ACC_W'(prod);
  always_ff @(posedge clk) begin
    if (rst) acc <= '0;
    else if (en) acc <= (first ? seed : acc) + ext;
  end
endmodule

// File: rtl/matrix_mul_stream_core.sv
// matrix_mul_stream_core: streamed C(+)=A*B engine; cfg_*/start job request, in_valid/in_ready/in_data operand load, out_valid/out_ready/out_data/out_last results, busy/done/cfg_err status
module matrix_mul_stream_core import matrix_mul_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int MAX_M = DEF_MAX,
  parameter int MAX_K = DEF_MAX,
  parameter int MAX_N = DEF_MAX
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [dim_w(MAX_M)-1:0] cfg_m,
  input  logic [dim_w(MAX_K)-1:0] cfg_k,
  input  logic [dim_w(MAX_N)-1:0] cfg_n,
  input  logic                    cfg_acc,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err
);
  localparam int MW = dim_w(MAX_M);
  localparam int KW = dim_w(MAX_K);
  localparam int NW = dim_w(MAX_N);
  localparam int AD = MAX_M * MAX_K;
  localparam int BD = MAX_K * MAX_N;
  localparam int CD = MAX_M * MAX_N;
  localparam int PD = AD > BD ? (AD > CD ? AD : CD) : (BD > CD ? BD : CD);
  localparam int PW = $clog2(PD + 1);
  localparam int AAW = addr_w(AD);
  localparam int BAW = addr_w(BD);
  localparam int CAW = addr_w(CD);
  state_t state, nxt;
  logic [MW-1:0] m_r, i;
  logic [KW-1:0] k_r, kk;
  logic [NW-1:0] n_r, j;
  logic acc_r;
  logic [PW-1:0] cnt, mk, kn, mn;
  logic [AAW-1:0] a_idx;
  logic [BAW-1:0] b_idx;
  logic [CAW-1:0] c_idx;
  logic [DATA_W-1:0] a_mem [AD];
  logic [DATA_W-1:0] b_mem [BD];
  logic [ACC_W-1:0] c_mem [CD];
  logic [ACC_W-1:0] acc;
  logic cfg_ok, in_fire, out_fire, a_end, b_end, c_end, cell_end, row_end, last_cell;
  assign mk = PW'(m_r) * PW'(k_r);
  assign kn = PW'(k_r) * PW'(n_r);
  assign mn = PW'(m_r) * PW'(n_r);
  assign a_idx = AAW'(PW'(i) * PW'(k_r) + PW'(kk));
  assign b_idx = BAW'(PW'(kk) * PW'(n_r) + PW'(j));
  assign c_idx = CAW'(PW'(i) * PW'(n_r) + PW'(j));
  assign cfg_ok = cfg_m != '0 && cfg_m <= MW'(MAX_M) && cfg_k != '0 && cfg_k <= KW'(MAX_K)
               && cfg_n != '0 && cfg_n <= NW'(MAX_N);
  assign a_end = cnt == mk - 1'b1;
  assign b_end = cnt == kn - 1'b1;
  assign c_end = cnt == mn - 1'b1;
  assign cell_end = kk == k_r;
  assign row_end = j == n_r - 1'b1;
  assign last_cell = cell_end && row_end && i == m_r - 1'b1;
  assign in_fire = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign out_data = out_valid ? c_mem[cnt[CAW-1:0]] : '0;
  assign out_last = out_valid && c_end;
  always_comb begin
    nxt = state;
    in_ready = 1'b0;
    out_valid = 1'b0;
    busy = state != IDLE;
    case (state)
      IDLE: nxt = start && cfg_ok ? LOAD_A : IDLE;
      LOAD_A: begin
        in_ready = 1'b1;
        nxt = in_valid && a_end ? LOAD_B : LOAD_A;
      end
      LOAD_B: begin
        in_ready = 1'b1;
        nxt = in_valid && b_end ? COMPUTE : LOAD_B;
      end
      COMPUTE: nxt = last_cell ? DRAIN : COMPUTE;
      DRAIN: begin
        out_valid = 1'b1;
        nxt = out_ready && c_end ? IDLE : DRAIN;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state <= nxt;
      done <= out_fire && out_last;
      cfg_err <= state == IDLE && start && !cfg_ok;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {m_r, k_r, n_r, acc_r} <= '0;
      cnt <= '0;
      i <= '0;
      j <= '0;
      kk <= '0;
    end else begin
      if (state == IDLE) begin
        cnt <= '0;
        i <= '0;
        j <= '0;
        kk <= '0;
        if (start && cfg_ok) {m_r, k_r, n_r, acc_r} <= {cfg_m, cfg_k, cfg_n, cfg_acc};
      end
      if (in_fire) cnt <= (state == LOAD_A ? a_end : b_end) ? '0 : cnt + 1'b1;
      if (out_fire) cnt <= cnt + 1'b1;
      if (state == COMPUTE) begin
        kk <= cell_end ? '0 : kk + 1'b1;
        if (cell_end) begin
          j <= row_end ? '0 : j + 1'b1;
          i <= row_end ? i + 1'b1 : i;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (in_fire && state == LOAD_A) a_mem[cnt[AAW-1:0]] <= in_data;
    if (in_fire && state == LOAD_B) b_mem[cnt[BAW-1:0]] <= in_data;
  end
  always_ff @(posedge clk) begin
    if (rst) for (int x = 0; x < CD; x++) c_mem[x] <= '0;
    else if (state == COMPUTE && cell_end) c_mem[c_idx] <= acc;
  end
  mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .clk(clk),
    .rst(rst),
    .en(state == COMPUTE && !cell_end),
    .first(kk == '0),
    .seed(acc_r ? c_mem[c_idx] : '0),
    .a(a_mem[a_idx]),
    .b(b_mem[b_idx]),
    .acc(acc)
  );
endmodule

// File: tb/tb_matrix_mul_stream_core.sv
// tb_matrix_mul_stream_core: randomized scoreboard bench for matrix_mul_stream_core against a plain matrix-arithmetic model
module tb_matrix_mul_stream_core;
  localparam int DW = 16;
  localparam int AW = 40;
  localparam int MX = 8;
  typedef struct {logic [AW-1:0] d; bit last;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] cfg_m = '0, cfg_k = '0, cfg_n = '0;
  logic cfg_acc = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic in_ready, out_valid, out_last, busy, done, cfg_err;
  logic [AW-1:0] out_data;
  exp_t exp_q[$];
  logic [AW-1:0] ref_c [MX*MX];
  int a_v [MX*MX];
  int b_v [MX*MX];
  int cmp = 0, err = 0;
  bit rand_rdy = 0, done_due = 0, prev_stall = 0;
  logic [AW-1:0] prev_d;
  logic prev_l;
  always #5 clk = ~clk;
  matrix_mul_stream_core dut (
    .clk(clk), .rst(rst), .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_n(cfg_n), .cfg_acc(cfg_acc),
    .start(start), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );
  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    cmp++;
    if (got !== want) begin
      err++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask
  always @(posedge clk) begin
    #1;
    out_ready = rand_rdy ? 1'($urandom_range(1)) : 1'b1;
  end
  always @(negedge clk) begin
    if (rst) begin
      done_due = 0;
      prev_stall = 0;
    end else begin
      if (done || done_due) check("done_pulse", 64'(done), 64'(done_due));
      done_due = 0;
      if (prev_stall) begin
        check("hold_valid", 64'(out_valid), 1);
        check("hold_data", 64'(out_data), 64'(prev_d));
        check("hold_last", 64'(out_last), 64'(prev_l));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_data", 64'(out_data), 64'(e.d));
          check("out_last", 64'(out_last), 64'(e.last));
          done_due = e.last;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_d = out_data;
      prev_l = out_last;
    end
  end
  task automatic run_job(input int m, input int k, input int n, input bit acc, input int gap, input bit abort);
    logic [AW-1:0] nc [MX*MX];
    longint s;
    int cyc;
    int word;
    bit rdy, got;
    nc = ref_c;
    for (int r = 0; r < m; r++)
      for (int c = 0; c < n; c++) begin
        s = acc ? longint'(ref_c[r*n+c]) : 64'sd0;
        for (int q = 0; q < k; q++) s += longint'(a_v[r*k+q]) * longint'(b_v[q*n+c]);
        nc[r*n+c] = s[AW-1:0];
        exp_q.push_back('{nc[r*n+c], (r*n+c) == m*n-1});
      end
    ref_c = nc;
    cfg_m = 4'(m);
    cfg_k = 4'(k);
    cfg_n = 4'(n);
    cfg_acc = acc;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", 64'(busy), 1);
    for (int w = 0; w < m*k + k*n; w++) begin
      word = w < m*k ? a_v[w] : b_v[w-m*k];
      cyc = 0;
      got = 0;
      while (!got) begin
        in_valid = $urandom_range(99) >= gap;
        in_data = DW'(word);
        @(negedge clk);
        rdy = in_ready;
        @(posedge clk);
        #1;
        got = rdy && in_valid;
        cyc++;
        if (cyc > 500) begin
          check("in_accept_timeout", 0, 1);
          in_valid = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
    if (abort) begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      foreach (ref_c[x]) ref_c[x] = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("busy_after_abort", 64'(busy), 0);
      repeat (6) @(posedge clk);
      #1;
      return;
    end
    cyc = 0;
    while (!out_valid && cyc < 5000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("compute_cycles", 64'(cyc), 64'(m*n*(k+1)));
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 5000);
    check("done_seen", 64'(done), 1);
  endtask
  task automatic fill_rand(input int cnt);
    logic signed [DW-1:0] t;
    for (int x = 0; x < cnt; x++) begin
      t = DW'($urandom);
      a_v[x] = t;
      t = DW'($urandom);
      b_v[x] = t;
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int m, k, n;
    foreach (ref_c[x]) ref_c[x] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", 64'(in_ready), 0);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_out_last", 64'(out_last), 0);
    check("rst_out_data", 64'(out_data), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_cfg_err", 64'(cfg_err), 0);
    a_v[0:5] = '{1, 2, 3, 4, 5, 6};
    b_v[0:5] = '{7, 8, 9, 10, 11, 12};
    run_job(2, 3, 2, 0, 0, 0);
    run_job(2, 3, 2, 1, 0, 0);
    check("ref_c0_doubled", 64'(ref_c[0]), 116);
    @(posedge clk);
    #1;
    for (int t = 0; t < 2; t++) begin
      cfg_m = t == 0 ? 4'd2 : 4'(MX + 1);
      cfg_k = t == 0 ? 4'd0 : 4'd2;
      cfg_n = 4'd2;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("cfg_err_pulse", 64'(cfg_err), 1);
      check("cfg_err_busy", 64'(busy), 0);
      check("cfg_err_in_ready", 64'(in_ready), 0);
      @(posedge clk);
      #1;
      check("cfg_err_clear", 64'(cfg_err), 0);
      check("cfg_err_idle", 64'(busy), 0);
    end
    a_v[0] = -32768;
    b_v[0] = -32768;
    rand_rdy = 1;
    run_job(1, 1, 1, 0, 0, 0);
    check("ref_min_sq", 64'(ref_c[0]), 1073741824);
    rand_rdy = 0;
    fill_rand(4);
    run_job(2, 2, 2, 1, 10, 1);
    a_v[0] = 2;
    b_v[0] = 3;
    run_job(1, 1, 1, 1, 0, 0);
    fill_rand(MX*MX);
    rand_rdy = 1;
    run_job(MX, MX, MX, 1, 40, 0);
    for (int t = 0; t < 4; t++) begin
      m = $urandom_range(MX, 1);
      k = $urandom_range(MX, 1);
      n = $urandom_range(MX, 1);
      rand_rdy = 1'($urandom_range(1));
      fill_rand(MX*MX);
      run_job(m, k, n, 1'($urandom_range(1)), 20, 0);
    end
    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
